// File: rtl/serv_alu_seq.sv
// Sequencer that feeds 32-bit operands to a bit/nibble-serial ALU in W-bit chunks
// and reassembles the serial result into a parallel word with a valid/ready handshake.
module serv_alu_seq #(
    parameter int W = 1
) (
    input  logic            clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_rs1,
    input  logic [31:0]     i_op_b,
    input  logic            i_sub,
    input  logic            i_cmp_eq,
    input  logic            i_cmp_sig,
    input  logic [1:0]      i_bool_op,
    input  logic [2:0]      i_rd_sel,
    output logic            o_alu_en,
    output logic            o_alu_cnt0,
    output logic            o_alu_sub,
    output logic            o_alu_cmp_eq,
    output logic            o_alu_cmp_sig,
    output logic [1:0]      o_alu_bool_op,
    output logic [2:0]      o_alu_rd_sel,
    output logic [W-1:0]    o_alu_rs1,
    output logic [W-1:0]    o_alu_op_b,
    output logic [W-1:0]    o_alu_buf,
    input  logic [W-1:0]    i_alu_rd,
    input  logic            i_alu_cmp,
    output logic            o_valid,
    output logic [31:0]     o_rd,
    output logic            o_cmp,
    input  logic            i_ready
);

    localparam int N  = 32 / W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rs1_q, rs1_d;
    logic [31:0]   opb_q, opb_d;
    logic [31:0]   res_q, res_d;
    logic          cmp_q, cmp_d;
    logic          sub_q, sub_d;
    logic          cmp_eq_q, cmp_eq_d;
    logic          cmp_sig_q, cmp_sig_d;
    logic [1:0]    bool_op_q, bool_op_d;
    logic [2:0]    rd_sel_q, rd_sel_d;

    logic run;
    assign run = (state_q == ST_RUN);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rs1_d     = rs1_q;
        opb_d     = opb_q;
        res_d     = res_q;
        cmp_d     = cmp_q;
        sub_d     = sub_q;
        cmp_eq_d  = cmp_eq_q;
        cmp_sig_d = cmp_sig_q;
        bool_op_d = bool_op_q;
        rd_sel_d  = rd_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    rs1_d     = i_rs1;
                    opb_d     = i_op_b;
                    res_d     = '0;
                    cnt_d     = '0;
                    sub_d     = i_sub;
                    cmp_eq_d  = i_cmp_eq;
                    cmp_sig_d = i_cmp_sig;
                    bool_op_d = i_bool_op;
                    rd_sel_d  = i_rd_sel;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                // Result enters from the top so the first chunk ends up in bits [W-1:0].
                rs1_d = {{W{1'b0}}, rs1_q[31:W]};
                opb_d = {{W{1'b0}}, opb_q[31:W]};
                res_d = {i_alu_rd, res_q[31:W]};
                if (cnt_q == CNT_LAST) begin
                    cmp_d   = i_alu_cmp;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rs1_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            cmp_q     <= 1'b0;
            sub_q     <= 1'b0;
            cmp_eq_q  <= 1'b0;
            cmp_sig_q <= 1'b0;
            bool_op_q <= 2'b00;
            rd_sel_q  <= 3'b000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rs1_q     <= rs1_d;
            opb_q     <= opb_d;
            res_q     <= res_d;
            cmp_q     <= cmp_d;
            sub_q     <= sub_d;
            cmp_eq_q  <= cmp_eq_d;
            cmp_sig_q <= cmp_sig_d;
            bool_op_q <= bool_op_d;
            rd_sel_q  <= rd_sel_d;
        end
    end

    // Operand chunks are gated so the ALU sees zeros whenever it is not enabled.
    for (genvar gi = 0; gi < W; gi++) begin : g_chunk
        assign o_alu_rs1[gi]  = run & rs1_q[gi];
        assign o_alu_op_b[gi] = run & opb_q[gi];
        assign o_alu_buf[gi]  = 1'b0;
    end

    assign o_ready       = (state_q == ST_IDLE);
    assign o_valid       = (state_q == ST_DONE);
    assign o_alu_en      = run;
    assign o_alu_cnt0    = run & (cnt_q == '0);
    assign o_alu_sub     = sub_q;
    assign o_alu_cmp_eq  = cmp_eq_q;
    assign o_alu_cmp_sig = cmp_sig_q;
    assign o_alu_bool_op = bool_op_q;
    assign o_alu_rd_sel  = rd_sel_q;
    assign o_rd          = res_q;
    assign o_cmp         = cmp_q;

endmodule
